id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- Operand-fetch stage and ID/EX pipeline register sitting directly upstream of the 16-bit ALU.
- Holds the 8x16 general register file (r0 hardwired to zero) and resolves operands with forwarding from the EX/MEM and WB stages.
- Registers a, b, cmd and writeback control, with stall and flush control for the hazard unit, and presents them to the ALU one cycle later.

Parameters:
- DATA_W, 16, datapath width; must match the ALU operand width.
- REG_NUM, 8, number of architectural registers.
- REG_AW, 3, register address width (log2 REG_NUM).

Ports:
- clk  in  1  stage clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  decoded instruction present this cycle.
- id_rs  in  3  source register 1 address.
- id_rt  in  3  source register 2 address.
- id_rd  in  3  destination register address.
- id_imm  in  16  sign/zero-extended immediate (extension done by decoder).
- id_use_imm  in  1  1: operand b = id_imm; 0: operand b = R[rt].
- id_alu_cmd  in  3  ALU command, `ALU_* encoding from mips_16_defs.v.
- id_reg_we  in  1  instruction writes id_rd.
- stall  in  1  hold the pipeline register.
- flush  in  1  insert bubble.
- exmem_we  in  1  EX/MEM result will be written back.
- exmem_rd  in  3  EX/MEM destination.
- exmem_data  in  16  EX/MEM ALU result.
- wb_we  in  1  writeback enable.
- wb_rd  in  3  writeback destination.
- wb_data  in  16  writeback data.
- ex_valid  out  1  registered instruction valid.
- ex_a  out  16  ALU operand a.
- ex_b  out  16  ALU operand b.
- ex_alu_cmd  out  3  ALU command.
- ex_rd  out  3  destination passed downstream.
- ex_reg_we  out  1  writeback enable passed downstream; forced 0 when ex_valid=0.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All 8 registers = 0.
  - ex_valid=0, ex_a=0, ex_b=0, ex_rd=0, ex_reg_we=0, ex_alu_cmd=`ALU_NC.
  - Reset asserted mid-stall or mid-flush clears everything immediately; first capture occurs on the first rising edge after rst_n rises.
- Register file:
  - 2 combinational read ports, 1 synchronous write port.
  - Write on a clk edge when wb_we=1 and wb_rd!=0; writes to r0 are ignored and r0 always reads 0.
- Operand resolution, evaluated combinationally each cycle for both rs and rt, in priority order:
  1. addr==0 -> 0.
  2. exmem_we && exmem_rd==addr -> exmem_data.
  3. wb_we && wb_rd==addr -> wb_data (write-through bypass, same-cycle read-during-write).
  4. Otherwise the register file value.
- Operand b:
  - b = id_use_imm ? id_imm : resolved R[rt].
  - Forwarding of rt still occurs but is discarded when id_use_imm=1.
- Pipeline register update, on each rising edge, in priority order:
  1. flush=1 -> bubble: ex_valid=0, ex_reg_we=0, ex_alu_cmd=`ALU_NC; ex_a/ex_b/ex_rd hold their previous values. flush wins over stall.
  2. else stall=1 -> all ex_* hold.
  3. else capture: ex_valid=id_valid, ex_a, ex_b, ex_alu_cmd=id_alu_cmd, ex_rd=id_rd, ex_reg_we=id_reg_we&id_valid. When id_valid=0, capture a bubble as in flush.
- Latency: exactly 1 cycle from id_* inputs to ex_* outputs. Throughput is 1 instruction per cycle when stall=0.
- Register file writes are never blocked by stall or flush.
- While stalled, id-side reads continue every cycle, so a WB write landing during the stall is reflected when the stall releases.
- No load-use detection in this block; the hazard unit drives stall/flush.

Decomposition:
- mips_16_defs.v holds:
  - the `ALU_* command codes (including `ALU_NC);
  - DATA width and REG_NUM/REG_AW defines;
  - the bubble command constant.
- Sub-module reg_file: 8x16, 2R1W, r0 = 0, async active-low reset.
- Forwarding muxes and the pipeline register stay in id_ex_stage.

Test Plan:
- Reset, then write R3=0x1234 via WB; issue rs=3, rt=0, use_imm=0, cmd=ADD -> next cycle ex_a=0x1234, ex_b=0x0000, ex_alu_cmd=`ALU_ADD, ex_valid=1.
- EX/MEM forward: R2=0x0005 in regfile, exmem_we=1, exmem_rd=2, exmem_data=0x00AA, wb_we=1, wb_rd=2, wb_data=0x0077; issue rs=2 -> ex_a=0x00AA. Repeat with exmem_we=0 -> ex_a=0x0077.
- r0 protection: wb_we=1, wb_rd=0, wb_data=0xFFFF, exmem_rd=0, exmem_data=0xBEEF, exmem_we=1; issue rs=0 -> ex_a=0x0000. Later read of r0 also returns 0.
- Immediate path: rt=4 (R4=0x1111), use_imm=1, imm=0xFFF0, cmd=SUB -> ex_b=0xFFF0.
- Stall/flush: capture instr A; hold stall=1 for 3 cycles while changing id_* -> ex_* stay A. Assert flush and stall together -> ex_valid=0, ex_reg_we=0, ex_alu_cmd=`ALU_NC.
- Async reset mid-stream: drop rst_n between edges -> outputs zero immediately without a clk edge. Registers read 0 after rst_n rises.

Source files
------------

// File: rtl/id_ex_stage_pkg.sv
// Shared constants for the ID/EX stage: datapath sizing and ALU command codes.
// The ALU command encoding matches the 16-bit ALU so commands pass through unchanged.
package id_ex_stage_pkg;

  localparam int unsigned DataW  = 16;
  localparam int unsigned RegNum = 8;
  localparam int unsigned RegAw  = 3;

  typedef enum logic [2:0] {
    AluNc  = 3'd0,
    AluAdd = 3'd1,
    AluSub = 3'd2,
    AluAnd = 3'd3,
    AluOr  = 3'd4,
    AluXor = 3'd5,
    AluSl  = 3'd6,
    AluSr  = 3'd7
  } alu_cmd_e;

  // Command presented to the ALU for an empty slot; the ALU treats it as a no-op.
  localparam logic [2:0] BubbleCmd = AluNc;

endpackage

// File: rtl/id_ex_stage_reg_file.sv
// General register file: two combinational read ports, one synchronous write port.
// Register 0 is hardwired to zero; writes to it are dropped.
module id_ex_stage_reg_file
  import id_ex_stage_pkg::*;
#(
  parameter int unsigned DATA_W  = DataW,
  parameter int unsigned REG_NUM = RegNum,
  parameter int unsigned REG_AW  = RegAw
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] ra0_i,
  output logic [DATA_W-1:0] rd0_o,
  input  logic [REG_AW-1:0] ra1_i,
  output logic [DATA_W-1:0] rd1_o,
  input  logic              we_i,
  input  logic [REG_AW-1:0] wa_i,
  input  logic [DATA_W-1:0] wd_i
);

  logic [DATA_W-1:0] mem_q [REG_NUM];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_NUM; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i && (wa_i != '0)) begin
      mem_q[wa_i] <= wd_i;
    end
  end

  assign rd0_o = (ra0_i == '0) ? '0 : mem_q[ra0_i];
  assign rd1_o = (ra1_i == '0) ? '0 : mem_q[ra1_i];

endmodule

// File: rtl/id_ex_stage.sv
// Operand fetch with EX/MEM and WB forwarding, followed by the ID/EX pipeline register
// feeding the ALU. Stall holds the register; flush (which beats stall) inserts a bubble.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int unsigned DATA_W  = DataW,
  parameter int unsigned REG_NUM = RegNum,
  parameter int unsigned REG_AW  = RegAw
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [DATA_W-1:0] id_imm,
  input  logic              id_use_imm,
  input  logic [2:0]        id_alu_cmd,
  input  logic              id_reg_we,
  input  logic              stall,
  input  logic              flush,
  input  logic              exmem_we,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic [DATA_W-1:0] exmem_data,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_a,
  output logic [DATA_W-1:0] ex_b,
  output logic [2:0]        ex_alu_cmd,
  output logic [REG_AW-1:0] ex_rd,
  output logic              ex_reg_we
);

  logic [DATA_W-1:0] rf_rs, rf_rt;
  logic [DATA_W-1:0] rs_val, rt_val, b_val;

  id_ex_stage_reg_file #(
    .DATA_W (DATA_W),
    .REG_NUM(REG_NUM),
    .REG_AW (REG_AW)
  ) u_reg_file (
    .clk  (clk),
    .rst_n(rst_n),
    .ra0_i(id_rs),
    .rd0_o(rf_rs),
    .ra1_i(id_rt),
    .rd1_o(rf_rt),
    .we_i (wb_we),
    .wa_i (wb_rd),
    .wd_i (wb_data)
  );

  // Youngest producer wins: EX/MEM is newer than WB, WB is newer than the array.
  function automatic logic [DATA_W-1:0] fwd_sel(
    input logic [REG_AW-1:0] addr,
    input logic [DATA_W-1:0] rf_val,
    input logic              em_we,
    input logic [REG_AW-1:0] em_rd,
    input logic [DATA_W-1:0] em_data,
    input logic              w_we,
    input logic [REG_AW-1:0] w_rd,
    input logic [DATA_W-1:0] w_data
  );
    if (addr == '0) begin
      return '0;
    end else if (em_we && (em_rd == addr)) begin
      return em_data;
    end else if (w_we && (w_rd == addr)) begin
      return w_data;
    end
    return rf_val;
  endfunction

  always_comb begin
    rs_val = fwd_sel(id_rs, rf_rs, exmem_we, exmem_rd, exmem_data, wb_we, wb_rd, wb_data);
    rt_val = fwd_sel(id_rt, rf_rt, exmem_we, exmem_rd, exmem_data, wb_we, wb_rd, wb_data);
    b_val  = id_use_imm ? id_imm : rt_val;
  end

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [2:0]        cmd_q, cmd_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic              we_q, we_d;

  // Bubbles only clear the control fields; operand and rd fields keep their last values.
  always_comb begin
    valid_d = valid_q;
    a_d     = a_q;
    b_d     = b_q;
    cmd_d   = cmd_q;
    rd_d    = rd_q;
    we_d    = we_q;
    if (flush || (!stall && !id_valid)) begin
      valid_d = 1'b0;
      we_d    = 1'b0;
      cmd_d   = BubbleCmd;
    end else if (!stall) begin
      valid_d = 1'b1;
      a_d     = rs_val;
      b_d     = b_val;
      cmd_d   = id_alu_cmd;
      rd_d    = id_rd;
      we_d    = id_reg_we;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      cmd_q   <= BubbleCmd;
      rd_q    <= '0;
      we_q    <= 1'b0;
    end else begin
      valid_q <= valid_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cmd_q   <= cmd_d;
      rd_q    <= rd_d;
      we_q    <= we_d;
    end
  end

  assign ex_valid   = valid_q;
  assign ex_a       = a_q;
  assign ex_b       = b_q;
  assign ex_alu_cmd = cmd_q;
  assign ex_rd      = rd_q;
  assign ex_reg_we  = we_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboarded bench for id_ex_stage: directed scenarios plus randomized traffic checked
// against an array-based architectural model.
module tb_id_ex_stage;
  import id_ex_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid, id_use_imm, id_reg_we, stall, flush, exmem_we, wb_we;
  logic [2:0]  id_rs, id_rt, id_rd, id_alu_cmd, exmem_rd, wb_rd;
  logic [15:0] id_imm, exmem_data, wb_data;
  logic        ex_valid, ex_reg_we;
  logic [15:0] ex_a, ex_b;
  logic [2:0]  ex_alu_cmd, ex_rd;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .id_valid  (id_valid),
    .id_rs     (id_rs),
    .id_rt     (id_rt),
    .id_rd     (id_rd),
    .id_imm    (id_imm),
    .id_use_imm(id_use_imm),
    .id_alu_cmd(id_alu_cmd),
    .id_reg_we (id_reg_we),
    .stall     (stall),
    .flush     (flush),
    .exmem_we  (exmem_we),
    .exmem_rd  (exmem_rd),
    .exmem_data(exmem_data),
    .wb_we     (wb_we),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .ex_valid  (ex_valid),
    .ex_a      (ex_a),
    .ex_b      (ex_b),
    .ex_alu_cmd(ex_alu_cmd),
    .ex_rd     (ex_rd),
    .ex_reg_we (ex_reg_we)
  );

  typedef struct packed {
    logic        v;
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  cmd;
    logic [2:0]  rd;
    logic        we;
  } ex_t;

  ex_t         exp_q[$];
  ex_t         m_ex;
  logic [15:0] m_rf [8];
  int          checks = 0;
  int          failures = 0;
  bit          mon_en = 1'b0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_rf[i] = 16'h0;
    m_ex = '{v: 1'b0, a: 16'h0, b: 16'h0, cmd: AluNc, rd: 3'd0, we: 1'b0};
  endtask

  // Architectural view of a source operand as seen by the instruction in decode.
  function automatic logic [15:0] model_read(input logic [2:0] addr);
    if (addr == 3'd0) return 16'h0;
    if (exmem_we && exmem_rd == addr) return exmem_data;
    if (wb_we && wb_rd == addr) return wb_data;
    return m_rf[addr];
  endfunction

  task automatic idle();
    id_valid = 0; id_rs = 0; id_rt = 0; id_rd = 0; id_imm = 0; id_use_imm = 0;
    id_alu_cmd = AluNc; id_reg_we = 0; stall = 0; flush = 0;
    exmem_we = 0; exmem_rd = 0; exmem_data = 0; wb_we = 0; wb_rd = 0; wb_data = 0;
  endtask

  task automatic issue(input logic [2:0] rs, input logic [2:0] rt, input logic [2:0] rd,
                       input logic [2:0] cmd, input logic use_imm, input logic [15:0] imm);
    id_valid = 1; id_rs = rs; id_rt = rt; id_rd = rd; id_alu_cmd = cmd;
    id_use_imm = use_imm; id_imm = imm; id_reg_we = 1;
  endtask

  // Predict the ex_* state after the coming edge, queue it, then advance one cycle.
  task automatic step();
    ex_t n = m_ex;
    if (flush) begin
      n.v = 0; n.we = 0; n.cmd = AluNc;
    end else if (!stall) begin
      if (id_valid) begin
        n.v   = 1;
        n.a   = model_read(id_rs);
        n.b   = id_use_imm ? id_imm : model_read(id_rt);
        n.cmd = id_alu_cmd;
        n.rd  = id_rd;
        n.we  = id_reg_we;
      end else begin
        n.v = 0; n.we = 0; n.cmd = AluNc;
      end
    end
    exp_q.push_back(n);
    if (wb_we && wb_rd != 3'd0) m_rf[wb_rd] = wb_data;
    m_ex = n;
    @(negedge clk);
  endtask

  initial begin : monitor
    ex_t e;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL scoreboard_underflow: got empty queue expected entry at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          check("sb_ex_valid", {15'h0, ex_valid}, {15'h0, e.v});
          check("sb_ex_a", ex_a, e.a);
          check("sb_ex_b", ex_b, e.b);
          check("sb_ex_alu_cmd", {13'h0, ex_alu_cmd}, {13'h0, e.cmd});
          check("sb_ex_rd", {13'h0, ex_rd}, {13'h0, e.rd});
          check("sb_ex_reg_we", {15'h0, ex_reg_we}, {15'h0, e.we});
        end
      end
    end
  end

  task automatic check_zero_outputs(input string tag);
    check({tag, "_valid"}, {15'h0, ex_valid}, 16'h0);
    check({tag, "_a"}, ex_a, 16'h0);
    check({tag, "_b"}, ex_b, 16'h0);
    check({tag, "_cmd"}, {13'h0, ex_alu_cmd}, {13'h0, AluNc});
    check({tag, "_rd"}, {13'h0, ex_rd}, 16'h0);
    check({tag, "_reg_we"}, {15'h0, ex_reg_we}, 16'h0);
  endtask

  initial begin : stimulus
    idle();
    model_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_zero_outputs("reset");
    rst_n = 1'b1;
    mon_en = 1'b1;

    // Plain register read after a WB write.
    idle(); wb_we = 1; wb_rd = 3'd3; wb_data = 16'h1234; step();
    idle(); issue(3'd3, 3'd0, 3'd5, AluAdd, 0, 16'h0); step();
    check("t1_ex_a", ex_a, 16'h1234);
    check("t1_ex_b", ex_b, 16'h0000);
    check("t1_ex_cmd", {13'h0, ex_alu_cmd}, {13'h0, AluAdd});
    check("t1_ex_valid", {15'h0, ex_valid}, 16'h1);

    // EX/MEM beats WB, WB beats the array.
    idle(); wb_we = 1; wb_rd = 3'd2; wb_data = 16'h0005; step();
    idle(); issue(3'd2, 3'd0, 3'd1, AluOr, 0, 16'h0);
    exmem_we = 1; exmem_rd = 3'd2; exmem_data = 16'h00AA;
    wb_we = 1; wb_rd = 3'd2; wb_data = 16'h0077; step();
    check("t2_exmem_fwd", ex_a, 16'h00AA);
    exmem_we = 0; step();
    check("t2_wb_fwd", ex_a, 16'h0077);

    // r0 ignores forwarding and writes.
    idle(); issue(3'd0, 3'd0, 3'd1, AluAdd, 0, 16'h0);
    wb_we = 1; wb_rd = 3'd0; wb_data = 16'hFFFF;
    exmem_we = 1; exmem_rd = 3'd0; exmem_data = 16'hBEEF; step();
    check("t3_r0_fwd", ex_a, 16'h0000);
    idle(); issue(3'd0, 3'd0, 3'd1, AluAdd, 0, 16'h0); step();
    check("t3_r0_read", ex_a, 16'h0000);

    // Immediate replaces rt.
    idle(); wb_we = 1; wb_rd = 3'd4; wb_data = 16'h1111; step();
    idle(); issue(3'd1, 3'd4, 3'd1, AluSub, 1, 16'hFFF0); step();
    check("t4_imm_b", ex_b, 16'hFFF0);
    check("t4_imm_cmd", {13'h0, ex_alu_cmd}, {13'h0, AluSub});

    // Stall holds, WB during stall lands, flush beats stall.
    idle(); issue(3'd3, 3'd4, 3'd6, AluAnd, 0, 16'h0); step();
    check("t5_capture_a", ex_a, 16'h1234);
    check("t5_capture_b", ex_b, 16'h1111);
    for (int i = 0; i < 3; i++) begin
      idle(); issue(3'($urandom_range(1, 7)), 3'($urandom_range(1, 7)), 3'd2, AluXor, 0, 16'h0);
      stall = 1;
      if (i == 1) begin wb_we = 1; wb_rd = 3'd3; wb_data = 16'hCAFE; end
      step();
      check("t5_stall_a", ex_a, 16'h1234);
      check("t5_stall_cmd", {13'h0, ex_alu_cmd}, {13'h0, AluAnd});
      check("t5_stall_rd", {13'h0, ex_rd}, 16'h6);
    end
    idle(); issue(3'd5, 3'd5, 3'd5, AluOr, 0, 16'h0); stall = 1; flush = 1; step();
    check("t5_flush_valid", {15'h0, ex_valid}, 16'h0);
    check("t5_flush_we", {15'h0, ex_reg_we}, 16'h0);
    check("t5_flush_cmd", {13'h0, ex_alu_cmd}, {13'h0, AluNc});
    check("t5_flush_hold_a", ex_a, 16'h1234);
    idle(); issue(3'd3, 3'd0, 3'd1, AluAdd, 0, 16'h0); step();
    check("t5_after_stall_wb", ex_a, 16'hCAFE);

    // Asynchronous reset between edges.
    mon_en = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_zero_outputs("async_rst");
    model_reset();
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;
    idle(); issue(3'd3, 3'd4, 3'd1, AluAdd, 0, 16'h0); step();
    check("t6_r3_cleared", ex_a, 16'h0000);
    check("t6_r4_cleared", ex_b, 16'h0000);

    // Randomized traffic with frequent address collisions.
    for (int i = 0; i < 400; i++) begin
      id_valid   = ($urandom_range(0, 3) != 0);
      id_rs      = 3'($urandom_range(0, 7));
      id_rt      = 3'($urandom_range(0, 7));
      id_rd      = 3'($urandom_range(0, 7));
      id_imm     = 16'($urandom);
      id_use_imm = 1'($urandom_range(0, 1));
      id_alu_cmd = 3'($urandom_range(0, 7));
      id_reg_we  = 1'($urandom_range(0, 1));
      stall      = ($urandom_range(0, 4) == 0);
      flush      = ($urandom_range(0, 9) == 0);
      exmem_we   = 1'($urandom_range(0, 1));
      exmem_rd   = 3'($urandom_range(0, 7));
      exmem_data = 16'($urandom);
      wb_we      = ($urandom_range(0, 3) != 0);
      wb_rd      = 3'($urandom_range(0, 7));
      wb_data    = 16'($urandom);
      step();
    end
    idle(); step(); step();
    check("queue_drained", 16'(exp_q.size()), 16'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
